// File: rtl/vector_mem_sequencer.sv
// Vector load/store sequencer: expands one LW_V/SW_V into per-element
// req/ack memory transfers and writes load results back into vector lanes.
module vector_mem_sequencer #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int VLEN_MAX = 8,
  parameter int IDX_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [IDX_W:0]    vlen,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [IDX_W-1:0]  vreg_rd_idx,
  input  logic [DATA_W-1:0] vreg_rd_data,
  output logic              vreg_we,
  output logic [IDX_W-1:0]  vreg_wr_idx,
  output logic [DATA_W-1:0] vreg_wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  typedef struct packed {
    logic              is_store;
    logic [ADDR_W-1:0] stride;
    logic [IDX_W:0]    len;
  } cmd_t;

  typedef struct packed {
    logic              vld;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } wb_t;

  localparam logic [IDX_W:0] VMAX    = (IDX_W+1)'(VLEN_MAX);
  localparam logic [IDX_W:0] LEN_ONE = (IDX_W+1)'(1);

  state_t            st, st_nxt;
  cmd_t              cmd;
  wb_t               wb;
  logic [IDX_W-1:0]  elem;
  logic [ADDR_W-1:0] addr;
  logic [IDX_W:0]    eff_len;
  logic              in_req, xfer, last;

  assign eff_len = (vlen > VMAX) ? VMAX : vlen;
  assign in_req  = (st == REQ);
  assign xfer    = in_req && mem_ack;
  assign last    = ({1'b0, elem} == (cmd.len - LEN_ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (start) st_nxt = (eff_len == '0) ? DONE : REQ;
      REQ:     if (xfer && last) st_nxt = DONE;
      DONE:    st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // Operands latch only in IDLE, so a start during an access cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd  <= '0;
      wb   <= '0;
      elem <= '0;
      addr <= '0;
    end else begin
      wb.vld <= 1'b0;
      if (st == IDLE && start) begin
        cmd  <= '{is_store: is_store, stride: stride, len: eff_len};
        elem <= '0;
        addr <= base_addr;
      end
      if (xfer) begin
        elem <= elem + IDX_W'(1);
        addr <= addr + cmd.stride;
        if (!cmd.is_store) wb <= '{vld: 1'b1, idx: elem, data: mem_rdata};
      end
    end
  end

  // Request-side outputs are gated by state so everything reads 0 outside REQ.
  assign mem_req      = in_req;
  assign mem_we       = in_req && cmd.is_store;
  assign mem_addr     = in_req ? addr : '0;
  assign mem_wdata    = in_req ? vreg_rd_data : '0;
  assign vreg_rd_idx  = in_req ? elem : '0;
  assign vreg_we      = wb.vld;
  assign vreg_wr_idx  = wb.vld ? wb.idx : '0;
  assign vreg_wr_data = wb.vld ? wb.data : '0;
  assign busy         = (st != IDLE);
  assign done         = (st == DONE);

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer: per-cycle checks plus a scoreboard
// of expected memory transfers and lane writebacks.
module tb_vector_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_store;
  logic [31:0] base_addr, stride;
  logic [3:0]  vlen;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  vreg_rd_idx, vreg_wr_idx;
  logic [31:0] vreg_rd_data, vreg_wr_data;
  logic        vreg_we, busy, done;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mem_t;
  typedef struct { logic [2:0] idx; logic [31:0] data; } wbx_t;

  mem_t exp_mem[$];
  wbx_t exp_wb[$];
  int   checks = 0, failures = 0;
  logic ack_force;
  int   ack_delay;
  int   wait_cnt = 0;

  always #5 clk = ~clk;

  vector_mem_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .base_addr(base_addr), .stride(stride), .vlen(vlen),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .vreg_rd_idx(vreg_rd_idx), .vreg_rd_data(vreg_rd_data),
    .vreg_we(vreg_we), .vreg_wr_idx(vreg_wr_idx), .vreg_wr_data(vreg_wr_data),
    .busy(busy), .done(done)
  );

  function automatic logic [31:0] lane(input logic [2:0] i);
    return 32'hC0DE_0000 | {29'd0, i};
  endfunction

  // Memory and register-file models
  assign mem_rdata    = mem_addr ^ 32'hA5;
  assign vreg_rd_data = lane(vreg_rd_idx);
  assign mem_ack      = ack_force | (mem_req && (wait_cnt >= ack_delay));

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumers
  always @(negedge clk) begin
    mem_t m;
    wbx_t w;
    if (rst_n && mem_req && mem_ack) begin
      chk("mem_sb_nonempty", 32'(exp_mem.size() != 0), 32'd1);
      if (exp_mem.size() != 0) begin
        m = exp_mem.pop_front();
        chk("sb_mem_addr", mem_addr, m.addr);
        chk("sb_mem_we", 32'(mem_we), 32'(m.we));
        if (m.we) chk("sb_mem_wdata", mem_wdata, m.wdata);
      end
    end
    if (rst_n && vreg_we) begin
      chk("wb_sb_nonempty", 32'(exp_wb.size() != 0), 32'd1);
      if (exp_wb.size() != 0) begin
        w = exp_wb.pop_front();
        chk("sb_wr_idx", 32'(vreg_wr_idx), 32'(w.idx));
        chk("sb_wr_data", vreg_wr_data, w.data);
      end
    end
  end

  // Called at a negedge; returns at the negedge of cycle 1.
  task automatic start_op(input logic st_i, input logic [31:0] b, input logic [31:0] s,
                          input logic [3:0] v);
    int          len;
    logic [31:0] a;
    len = (v > 4'd8) ? 8 : int'(v);
    a   = b;
    for (int i = 0; i < len; i++) begin
      exp_mem.push_back('{we: st_i, addr: a, wdata: lane(3'(i))});
      if (!st_i) exp_wb.push_back('{idx: 3'(i), data: a ^ 32'hA5});
      a = a + s;
    end
    is_store = st_i; base_addr = b; stride = s; vlen = v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; base_addr = '0; stride = '0; vlen = '0;
    ack_force = 1'b0; ack_delay = 0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rd_idx", 32'(vreg_rd_idx), 0);
    chk("rst_vreg_we", 32'(vreg_we), 0);
    chk("rst_wr_idx", 32'(vreg_wr_idx), 0);
    chk("rst_wr_data", vreg_wr_data, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Load, ack tied high (also acks while idle, which must be ignored)
    ack_force = 1'b1;
    @(negedge clk);
    chk("idle_ack_busy", 32'(busy), 0);
    start_op(1'b0, 32'h100, 32'd4, 4'd4);
    for (int c = 1; c <= 6; c++) begin
      chk("t1_req", 32'(mem_req), 32'(c <= 4));
      if (c <= 4) chk("t1_addr", mem_addr, 32'h100 + 32'(4 * (c - 1)));
      chk("t1_vreg_we", 32'(vreg_we), 32'(c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) chk("t1_wr_idx", 32'(vreg_wr_idx), 32'(c - 2));
      chk("t1_done", 32'(done), 32'(c == 5));
      chk("t1_busy", 32'(busy), 32'(c <= 5));
      @(negedge clk);
    end

    // Store, ack after two wait cycles per element
    ack_force = 1'b0; ack_delay = 2;
    start_op(1'b1, 32'h0, 32'd8, 4'd3);
    for (int c = 1; c <= 11; c++) begin
      chk("t2_req", 32'(mem_req), 32'(c <= 9));
      if (c <= 9) begin
        chk("t2_addr", mem_addr, 32'(8 * ((c - 1) / 3)));
        chk("t2_we", 32'(mem_we), 1);
        chk("t2_wdata", mem_wdata, lane(3'((c - 1) / 3)));
      end
      chk("t2_vreg_we", 32'(vreg_we), 0);
      chk("t2_done", 32'(done), 32'(c == 10));
      chk("t2_busy", 32'(busy), 32'(c <= 10));
      @(negedge clk);
    end

    // Negative stride wraps
    ack_force = 1'b1;
    start_op(1'b0, 32'h4, 32'hFFFF_FFF8, 4'd2);
    chk("t3_addr0", mem_addr, 32'h4);
    @(negedge clk);
    chk("t3_addr1", mem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("t3_done", 32'(done), 1);
    @(negedge clk);

    // Zero length: straight to DONE
    start_op(1'b0, 32'h40, 32'd4, 4'd0);
    chk("t4a_req", 32'(mem_req), 0);
    chk("t4a_done", 32'(done), 1);
    chk("t4a_busy", 32'(busy), 1);
    @(negedge clk);
    chk("t4a_idle", 32'(busy), 0);
    chk("t4a_done_low", 32'(done), 0);

    // Over-length clamps to 8
    start_op(1'b0, 32'h1000, 32'd4, 4'd15);
    for (int c = 1; c <= 9; c++) begin
      chk("t4b_req", 32'(mem_req), 32'(c <= 8));
      if (c == 9) begin
        chk("t4b_done", 32'(done), 1);
        chk("t4b_vreg_we", 32'(vreg_we), 1);
        chk("t4b_last_idx", 32'(vreg_wr_idx), 7);
      end
      @(negedge clk);
    end
    @(negedge clk);

    // Start while busy is ignored
    ack_force = 1'b0; ack_delay = 1;
    start_op(1'b1, 32'h200, 32'h10, 4'd3);
    for (int c = 1; c <= 8; c++) begin
      chk("t5_req", 32'(mem_req), 32'(c <= 6));
      if (c <= 6) begin
        chk("t5_addr", mem_addr, 32'h200 + 32'(16 * ((c - 1) / 2)));
        chk("t5_we", 32'(mem_we), 1);
      end
      chk("t5_done", 32'(done), 32'(c == 7));
      chk("t5_busy", 32'(busy), 32'(c <= 7));
      if (c == 2) begin
        start = 1'b1; base_addr = 32'h900; is_store = 1'b0; vlen = 4'd1; stride = 32'd4;
      end
      if (c == 3) start = 1'b0;
      @(negedge clk);
    end

    // Reset in the middle of a 4-element load
    ack_force = 1'b1;
    start_op(1'b0, 32'h300, 32'd4, 4'd4);
    @(negedge clk);
    @(negedge clk);
    chk("t6_pre_req", 32'(mem_req), 1);
    chk("t6_pre_vreg_we", 32'(vreg_we), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_req", 32'(mem_req), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_vreg_we", 32'(vreg_we), 0);
    chk("t6_rst_done", 32'(done), 0);
    exp_mem.delete();
    exp_wb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6_post_busy", 32'(busy), 0);
      chk("t6_post_done", 32'(done), 0);
      chk("t6_post_vreg_we", 32'(vreg_we), 0);
      chk("t6_post_req", 32'(mem_req), 0);
    end
    start_op(1'b0, 32'h500, 32'd8, 4'd2);
    chk("t6_new_addr0", mem_addr, 32'h500);
    @(negedge clk);
    chk("t6_new_addr1", mem_addr, 32'h508);
    @(negedge clk);
    chk("t6_new_done", 32'(done), 1);
    @(negedge clk);
    @(negedge clk);

    chk("sb_mem_drained", 32'(exp_mem.size()), 0);
    chk("sb_wb_drained", 32'(exp_wb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_mem_sequencer.md
Name: vector_mem_sequencer

Overview:
Sequences LW_V / SW_V vector memory instructions as a series of per-element data-memory accesses using a req/ack handshake.
- Loads: each returned element is written into the destination vector register lane.
- Stores: each element is read from the source vector register lane and sent to memory.
- Holds `busy` high to stall the pipeline while a vector access is in progress.
- Sits between the decode/execute stage (which supplies the start command) and the data memory / vector register file.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, element / memory data width
- VLEN_MAX, 8, maximum elements per vector access
- IDX_W, 3, lane index width (log2 VLEN_MAX)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch a vector access; sampled only in IDLE
- is_store  in  1  1 = SW_V, 0 = LW_V; latched with start
- base_addr  in  ADDR_W  address of element 0; latched with start
- stride  in  ADDR_W  two's-complement byte stride between elements; latched with start
- vlen  in  IDX_W+1  element count; latched with start
- mem_req  out  1  memory request valid
- mem_we  out  1  write enable, valid while mem_req
- mem_addr  out  ADDR_W  element address
- mem_wdata  out  DATA_W  store data (equals vreg_rd_data)
- mem_ack  in  1  memory accepts the request; load data valid in the same cycle
- mem_rdata  in  DATA_W  load data
- vreg_rd_idx  out  IDX_W  lane currently being stored
- vreg_rd_data  in  DATA_W  combinational read data for vreg_rd_idx
- vreg_we  out  1  lane write enable (loads)
- vreg_wr_idx  out  IDX_W  lane written
- vreg_wr_data  out  DATA_W  lane write data
- busy  out  1  pipeline stall; high whenever state != IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; element counter, address and pending writeback are cleared.
  - All outputs read 0.
  - Applies mid-operation: the access is abandoned, mem_req drops immediately, and no vreg_we follows reset release.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - start=1 latches is_store, base_addr, stride and the effective length L = min(vlen, VLEN_MAX).
  - L>0 -> REQ with elem=0 and addr=base_addr.
  - L=0 -> DONE directly; no mem_req is ever issued.
- REQ:
  - mem_req=1, mem_we=is_store, mem_addr=addr.
  - vreg_rd_idx=elem; mem_wdata=vreg_rd_data.
  - Outputs are held stable until mem_ack.
  - Transfer occurs on a cycle with mem_req & mem_ack. Ack in the first request cycle is legal, so back-to-back transfers run one element per cycle.
  - On a transfer:
    - elem increments.
    - addr = addr + stride, modulo 2^ADDR_W; negative stride wraps naturally.
    - If elem was L-1 -> DONE; otherwise stay in REQ.
  - Ack with mem_req=0 is ignored.
- Load writeback:
  - On a load transfer, mem_rdata and elem are registered.
  - Next cycle: vreg_we=1, vreg_wr_idx=that elem, vreg_wr_data=that data.
  - vreg_we is a one-cycle pulse per element.
  - The final lane's write occurs in the DONE cycle.
  - Stores never assert vreg_we.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then IDLE.
  - Next start is accepted in the cycle after DONE.
- start while state != IDLE is ignored, with no effect on latched operands.
- Latency: with start sampled at edge 0 and immediate acks, the mem_req cycles are 1..L and done is in cycle L+1. Each cycle without ack adds one cycle.
- vlen > VLEN_MAX is clamped to VLEN_MAX; lane indices never exceed VLEN_MAX-1.

Test Plan:
- **Load, immediate ack:** load, base=0x100, stride=4, vlen=4, mem_ack tied 1, mem_rdata=addr^0xA5.
  - mem_addr is 0x100, 0x104, 0x108, 0x10C in cycles 1-4.
  - vreg_we in cycles 2-5 with idx 0-3 and matching data.
  - done in cycle 5; busy is high in cycles 1-5.
- **Store with delayed ack:** store, base=0x0, stride=8, vlen=3, ack delayed 2 cycles per element.
  - mem_we=1; each address is held 3 cycles: 0x0, 0x8, 0x10.
  - mem_wdata equals lane 0/1/2 data.
  - No vreg_we; done in cycle 10.
- **Negative stride wrap:** base=0x4, stride=0xFFFFFFF8, vlen=2 -> addresses 0x4 then 0xFFFFFFFC.
- **Zero and over-length vlen:**
  - vlen=0: no mem_req, done in cycle 1.
  - vlen=15: exactly 8 transfers, last vreg_wr_idx=7.
- **Start while busy:** start pulsed during REQ with different base -> ignored; addresses continue from the original base.
- **Reset mid-operation:** rst_n low after element 1 of 4.
  - mem_req, busy and vreg_we drop at once.
  - After release: IDLE, no done, a new start runs normally.
